i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 16: audio word width per channel, with 1 <= DATA_BIT <= SLOT_BITS-1.
REQ-002 The block SHALL have parameter SLOT_BITS, default 32: SCLK periods per channel slot (64 SCLKs per frame).
REQ-003 The block SHALL have port i_clk_12_288, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_sclk_rise, input, 1 bit: one-cycle strobe marking each SCLK rising edge, synchronous to i_clk_12_288.
REQ-006 The block SHALL have port i_lrclk, input, 1 bit: word select (0 = left, 1 = right), changes only between strobes.
REQ-007 The block SHALL have port i_sd, input, 1 bit: serial data, MSB first, stable at each strobe.
REQ-008 The block SHALL have port o_audio_l, output, DATA_BIT bits: last complete left word.
REQ-009 The block SHALL have port o_audio_r, output, DATA_BIT bits: last complete right word.
REQ-010 The block SHALL have port o_data_valid, output, 1 bit: one-cycle pulse when a new L/R pair is presented.
REQ-011 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse on a slot-length violation.

Function
REQ-012 The block SHALL update all state only on cycles with i_sclk_rise=1, except pulse clearing (REQ-021).
REQ-013 At each strobe, the block SHALL register i_lrclk into lr_prev; a strobe where i_lrclk != lr_prev SHALL be a slot boundary.
REQ-014 The block SHALL use a slot bit counter cnt, sized $clog2(SLOT_BITS): cnt=0 at a boundary strobe, otherwise cnt+1, saturating at SLOT_BITS-1.
REQ-015 The block SHALL apply the standard I2S one-bit delay: the boundary-strobe sample belongs to the previous slot and is discarded; word bits are sampled at strobes where the new cnt is 1..DATA_BIT, MSB at cnt=1, shifted into a DATA_BIT shift register; samples with cnt > DATA_BIT are ignored.
REQ-016 The FSM SHALL have states SYNC, LEFT, RIGHT; reset state SYNC.
REQ-017 In SYNC, the FSM SHALL go to LEFT on a boundary with i_lrclk=0 (falling LRCLK); all other strobes are ignored and no output is produced.
REQ-018 In LEFT, at the strobe where cnt becomes DATA_BIT, the shift content (including that strobe's bit) SHALL be latched into an internal left holding register; on a boundary with i_lrclk=1, the FSM SHALL go to RIGHT.
REQ-019 In RIGHT, at the strobe where cnt becomes DATA_BIT, the FSM SHALL load o_audio_l from the left holding register and o_audio_r from the shift content, and assert o_data_valid on the next clock (1-cycle latency after that strobe); on a boundary with i_lrclk=0, the FSM SHALL go to LEFT.
REQ-020 In LEFT or RIGHT, a boundary strobe with prior cnt != SLOT_BITS-1 SHALL pulse o_frame_err, discard the partial pair, and move the FSM to SYNC; the same strobe SHALL then be evaluated as a SYNC boundary (a falling edge enters LEFT directly).
REQ-021 The block SHALL ensure o_data_valid and o_frame_err are each high for exactly one i_clk_12_288 cycle per event and never high together.
REQ-022 The block SHALL hold o_audio_l and o_audio_r stable between valid pulses.
REQ-023 If i_sclk_rise stops, the block SHALL hold all state indefinitely.

Reset
REQ-024 While i_reset_n=0, the block SHALL asynchronously clear o_audio_l, o_audio_r, o_data_valid, o_frame_err, cnt, the shift register, the left holding register, and lr_prev, and set the FSM to SYNC.
REQ-025 A reset mid-frame SHALL discard the partial data, and the block SHALL produce no output until the next falling LRCLK boundary after release.

Verification
REQ-026 The bench SHALL drive a full frame L=16'hA5A5, R=16'h5A5A (SLOT_BITS=32) after sync -> o_data_valid pulses once, 1 clk after right cnt=16 strobe, o_audio_l=A5A5, o_audio_r=5A5A.
REQ-027 The bench SHALL start the stream mid right-slot -> no valid until the first falling boundary; the first full pair output is correct.
REQ-028 The bench SHALL send 4 back-to-back frames (8000/0001, FFFF/0000, 1234/ABCD, 7FFF/8001) -> exactly 4 valid pulses, 64 strobes apart, each with correct values.
REQ-029 The bench SHALL shorten the left slot to 20 SCLKs -> o_frame_err pulses at the boundary, no valid for that frame, and the next frame decodes correctly.
REQ-030 The bench SHALL assert i_reset_n=0 at left cnt=10 -> all outputs 0 immediately, and the first valid follows the next complete frame.
REQ-031 The bench SHALL gate i_sclk_rise for 500 clks mid-slot -> no state change, and decode resumes correctly.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver on an SCLK-rise strobe, one-bit delayed,
// MSB-first words, L/R pair output with slot-length error detection.
module i2s_rx #(
  parameter int DATA_BIT  = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                i_clk_12_288,
  input  logic                i_reset_n,
  input  logic                i_sclk_rise,
  input  logic                i_lrclk,
  input  logic                i_sd,
  output logic [DATA_BIT-1:0] o_audio_l,
  output logic [DATA_BIT-1:0] o_audio_r,
  output logic                o_data_valid,
  output logic                o_frame_err
);

  localparam int CW = $clog2(SLOT_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BIT - 1);

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_lr_prev;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [DATA_BIT-1:0] r_shift;
  logic [DATA_BIT-1:0] r_left_hold;
  logic [DATA_BIT-1:0] w_shift_nxt;
  logic                w_bound;
  logic                w_sample;
  logic                w_word_done;
  logic                w_err;
  logic                w_latch_l;
  logic                w_latch_r;

  // Boundary detect, saturating slot counter and word-bit window.
  always_comb begin
    w_bound   = i_sclk_rise && (i_lrclk != r_lr_prev);
    w_cnt_nxt = r_cnt;
    if (w_bound) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_sample    = i_sclk_rise && !w_bound && (r_cnt <= CNT_LAST);
    w_word_done = w_sample && (r_cnt == CNT_LAST);
    w_shift_nxt = DATA_BIT'({r_shift, i_sd});
  end

  // Next-state and latch/error decode.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_latch_l   = 1'b0;
    w_latch_r   = 1'b0;
    unique case (r_state)
      SYNC: begin
        if (w_bound && !i_lrclk) begin
          w_state_nxt = LEFT;
        end
      end
      LEFT, RIGHT: begin
        if (w_bound) begin
          if (r_cnt != CNT_MAX) begin
            w_err       = 1'b1;
            w_state_nxt = i_lrclk ? SYNC : LEFT;
          end else begin
            w_state_nxt = i_lrclk ? RIGHT : LEFT;
          end
        end
        w_latch_l = (r_state == LEFT) && w_word_done;
        w_latch_r = (r_state == RIGHT) && w_word_done;
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, output words and single-cycle pulses.
  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lr_prev    <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      o_audio_l    <= '0;
      o_audio_r    <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= w_latch_r;
      o_frame_err  <= w_err;
      if (i_sclk_rise) begin
        r_lr_prev <= i_lrclk;
        r_cnt     <= w_cnt_nxt;
      end
      if (w_sample) begin
        r_shift <= w_shift_nxt;
      end
      if (w_latch_l) begin
        r_left_hold <= w_shift_nxt;
      end
      if (w_latch_r) begin
        o_audio_l <= r_left_hold;
        o_audio_r <= w_shift_nxt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: slot-level reference model plus directed and random
// streams for the I2S receiver.
module tb_i2s_rx;

  localparam int DB = 16;
  localparam int SB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sclk_rise;
  logic          lrclk;
  logic          sd;
  logic [DB-1:0] audio_l;
  logic [DB-1:0] audio_r;
  logic          dv;
  logic          fe;

  i2s_rx #(
    .DATA_BIT (DB),
    .SLOT_BITS(SB)
  ) dut (
    .i_clk_12_288(clk),
    .i_reset_n   (rst_n),
    .i_sclk_rise (sclk_rise),
    .i_lrclk     (lrclk),
    .i_sd        (sd),
    .o_audio_l   (audio_l),
    .o_audio_r   (audio_r),
    .o_data_valid(dv),
    .o_frame_err (fe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] l;
    logic [DB-1:0] r;
    logic [DB-1:0] exp_l;
    logic [DB-1:0] exp_r;
  } frame_t;

  int checks   = 0;
  int failures = 0;

  bit            q_lr[$];
  int            q_len[$];
  logic [DB-1:0] q_word[$];

  int            obs_idx[$];
  logic [DB-1:0] obs_l[$];
  logic [DB-1:0] obs_r[$];
  int            n_err;

  logic [DB-1:0] m_l = '0;
  logic [DB-1:0] m_r = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stream();
    q_lr.delete();
    q_len.delete();
    q_word.delete();
  endtask

  task automatic add_slot(bit lr, int len, logic [DB-1:0] w);
    q_lr.push_back(lr);
    q_len.push_back(len);
    q_word.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sclk_rise = 1'b0;
    #1;
    check("rst_audio_l", audio_l, 0);
    check("rst_audio_r", audio_r, 0);
    check("rst_valid", dv, 0);
    check("rst_ferr", fe, 0);
    m_l = '0;
    m_r = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pause500();
    sclk_rise = 1'b0;
    repeat (500) begin
      @(negedge clk);
      check("pause_pulses", {dv, fe}, 0);
      check("pause_l", audio_l, m_l);
      check("pause_r", audio_r, m_r);
    end
  endtask

  // Expected events come from slot-level rules: a boundary while synced
  // after a short slot is an error; a synced right slot long enough to
  // carry a word yields the pair (previous left word, this right word).
  task automatic play(int pause_at);
    int total = 0;
    int idx;
    bit synced;
    int ev[];
    logic [DB-1:0] vl[];
    logic [DB-1:0] vr[];
    foreach (q_len[k]) total += q_len[k];
    ev = new[total];
    vl = new[total];
    vr = new[total];
    foreach (ev[i]) ev[i] = 0;
    idx = 0;
    synced = 1'b0;
    foreach (q_len[k]) begin
      if (k > 0) begin
        if (synced && q_len[k-1] < SB) begin
          ev[idx] = 2;
          synced = !q_lr[k];
        end else if (!q_lr[k]) begin
          synced = 1'b1;
        end
      end
      if (q_lr[k] && synced && q_len[k] > DB) begin
        ev[idx+DB] = 1;
        vl[idx+DB] = q_word[k-1];
        vr[idx+DB] = q_word[k];
      end
      idx += q_len[k];
    end
    obs_idx.delete();
    obs_l.delete();
    obs_r.delete();
    n_err = 0;
    idx = 0;
    foreach (q_len[k]) begin
      logic [DB-1:0] w;
      w = q_word[k];
      for (int j = 0; j < q_len[k]; j++) begin
        logic b;
        b = (j >= 1 && j <= DB) ? w[DB-j] : 1'($urandom_range(0, 1));
        if (idx == pause_at) pause500();
        @(negedge clk);
        sclk_rise = 1'b1;
        lrclk = q_lr[k];
        sd = b;
        @(negedge clk);
        sclk_rise = 1'b0;
        if (ev[idx] == 1) begin
          m_l = vl[idx];
          m_r = vr[idx];
        end
        check("valid", dv, ev[idx] == 1);
        check("frame_err", fe, ev[idx] == 2);
        check("audio_l", audio_l, m_l);
        check("audio_r", audio_r, m_r);
        if (dv) begin
          obs_idx.push_back(idx);
          obs_l.push_back(audio_l);
          obs_r.push_back(audio_r);
        end
        if (fe) n_err++;
        repeat (2) begin
          @(negedge clk);
          check("idle_pulses", {dv, fe}, 0);
        end
        idx++;
      end
    end
  endtask

  frame_t tbl[4];

  initial begin
    tbl[0] = '{16'h8000, 16'h0001, 16'h8000, 16'h0001};
    tbl[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[2] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
    tbl[3] = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001};
    rst_n = 1'b0;
    sclk_rise = 1'b0;
    lrclk = 1'b0;
    sd = 1'b0;
    repeat (3) @(negedge clk);
    check("init_audio_l", audio_l, 0);
    check("init_audio_r", audio_r, 0);
    check("init_pulses", {dv, fe}, 0);
    rst_n = 1'b1;

    // Single frame after sync.
    clear_stream();
    add_slot(1, SB, DB'($urandom));
    add_slot(0, SB, 16'hA5A5);
    add_slot(1, SB, 16'h5A5A);
    play(-1);
    check("f1_count", obs_idx.size(), 1);
    if (obs_idx.size() == 1) begin
      check("f1_idx", obs_idx[0], 2 * SB + DB);
      check("f1_l", obs_l[0], 16'hA5A5);
      check("f1_r", obs_r[0], 16'h5A5A);
    end

    // Start mid right slot.
    do_reset();
    clear_stream();
    add_slot(1, 13, DB'($urandom));
    add_slot(0, SB, 16'hC3C3);
    add_slot(1, SB, 16'h3C3C);
    play(-1);
    check("mid_count", obs_idx.size(), 1);
    if (obs_idx.size() == 1) begin
      check("mid_idx", obs_idx[0], 13 + SB + DB);
      check("mid_l", obs_l[0], 16'hC3C3);
      check("mid_r", obs_r[0], 16'h3C3C);
    end

    // Back-to-back frames from the table.
    do_reset();
    clear_stream();
    add_slot(1, SB, DB'($urandom));
    for (int i = 0; i < 4; i++) begin
      add_slot(0, SB, tbl[i].l);
      add_slot(1, SB, tbl[i].r);
    end
    play(-1);
    check("b2b_count", obs_idx.size(), 4);
    if (obs_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_l", obs_l[i], tbl[i].exp_l);
        check("b2b_r", obs_r[i], tbl[i].exp_r);
        if (i > 0) check("b2b_gap", obs_idx[i] - obs_idx[i-1], 2 * SB);
      end
    end

    // Short left slot.
    do_reset();
    clear_stream();
    add_slot(1, SB, DB'($urandom));
    add_slot(0, SB, 16'h1111);
    add_slot(1, SB, 16'h2222);
    add_slot(0, 20, 16'h3333);
    add_slot(1, SB, 16'h4444);
    add_slot(0, SB, 16'h5555);
    add_slot(1, SB, 16'h6666);
    play(-1);
    check("short_errs", n_err, 1);
    check("short_count", obs_idx.size(), 2);
    if (obs_idx.size() == 2) begin
      check("short_idx", obs_idx[1], 3 * SB + 20 + 2 * SB + DB);
      check("short_l", obs_l[1], 16'h5555);
      check("short_r", obs_r[1], 16'h6666);
    end

    // Reset at left cnt=10.
    do_reset();
    clear_stream();
    add_slot(1, SB, DB'($urandom));
    add_slot(0, SB, 16'hBEEF);
    add_slot(1, SB, 16'hCAFE);
    add_slot(0, 11, 16'h0F0F);
    play(-1);
    check("pre_rst_l", audio_l, 16'hBEEF);
    do_reset();
    clear_stream();
    add_slot(0, SB - 11, DB'($urandom));
    add_slot(1, SB, DB'($urandom));
    add_slot(0, SB, 16'h1357);
    add_slot(1, SB, 16'h2468);
    play(-1);
    check("rst_count", obs_idx.size(), 1);
    if (obs_idx.size() == 1) begin
      check("rst_idx", obs_idx[0], (SB - 11) + 2 * SB + DB);
      check("rst_l", obs_l[0], 16'h1357);
      check("rst_r", obs_r[0], 16'h2468);
    end

    // Strobe gated mid left slot.
    do_reset();
    clear_stream();
    add_slot(1, SB, DB'($urandom));
    add_slot(0, SB, 16'h9876);
    add_slot(1, SB, 16'h5432);
    play(SB + 7);
    check("gate_count", obs_idx.size(), 1);
    if (obs_idx.size() == 1) begin
      check("gate_l", obs_l[0], 16'h9876);
      check("gate_r", obs_r[0], 16'h5432);
    end

    // Random slot lengths and words against the slot-level model.
    do_reset();
    clear_stream();
    begin
      bit lr;
      lr = 1'($urandom_range(0, 1));
      for (int k = 0; k < 120; k++) begin
        int r;
        int len;
        r = $urandom_range(0, 9);
        if (r < 7) len = SB;
        else if (r < 9) len = $urandom_range(2, SB - 1);
        else len = $urandom_range(SB + 1, SB + 3);
        add_slot(lr, len, DB'($urandom));
        lr = !lr;
      end
    end
    play(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
